// File: rtl/moon_pkg.sv
// Shared types and defaults for the terrain scroller: FSM states, world/column
// geometry defaults and the terrain LFSR seed, tap mask and step function.
package moon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam int          WORLD_W_DEF   = 640;
  localparam int          COL_W_DEF     = 8;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  // Right-shifting Fibonacci form of taps 16,14,13,11 (state bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS     = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/terrain_scroll_lfsr16.sv
// 16-bit Fibonacci LFSR terrain generator; advances one step per adv_i pulse.
module lfsr16
  import moon_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] r_state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SEED;
    end else if (adv_i) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign state_o = r_state;

endmodule

// File: rtl/terrain_scroll.sv
// Side-scroll offset tracker and terrain column emitter with valid/ready output.
// Optional acceleration levels are enabled by defining SCROLL_ACCEL_EN.
module terrain_scroll
  import moon_pkg::*;
#(
  parameter int          WORLD_W   = WORLD_W_DEF,
  parameter int          COL_W     = COL_W_DEF,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scroll_tog_i,
  input  logic       run_i,
  input  logic [1:0] speed_i,
  input  logic       col_ready_i,
  output logic [9:0] offset_o,
  output logic       col_valid_o,
  output logic [7:0] col_data_o,
  output logic       stall_o,
  output logic [1:0] level_o
);

  // acc < COL_W and step < COL_W, so acc+step always fits in one extra bit.
  localparam int               ACC_W   = $clog2(COL_W) + 1;
  localparam logic [10:0]      WORLD_L = 11'(WORLD_W);
  localparam logic [ACC_W-1:0] COL_L   = ACC_W'(COL_W);

  state_t           r_state, w_state_nxt;
  logic             r_tog, r_col_valid, r_data_en, r_stall;
  logic [9:0]       r_offset;
  logic [ACC_W-1:0] r_acc, w_acc_sum;
  logic [10:0]      w_off_sum, w_off_nxt;
  logic [2:0]       w_step;
  logic [1:0]       w_level;
  logic [15:0]      w_lfsr;
  logic             w_tick, w_hs, w_blocked, w_accept, w_emit, w_drop;
  logic             w_unused;

  assign w_tick    = scroll_tog_i ^ r_tog;
  assign w_step    = 3'(speed_i) + 3'd1 + 3'(w_level);
  assign w_off_sum = {1'b0, r_offset} + 11'(w_step);
  assign w_off_nxt = (w_off_sum >= WORLD_L) ? (w_off_sum - WORLD_L) : w_off_sum;
  assign w_acc_sum = r_acc + ACC_W'(w_step);

  assign w_hs      = r_col_valid & col_ready_i;
  assign w_blocked = r_col_valid & ~col_ready_i;
  assign w_accept  = w_tick & (r_state == ST_RUN) & ~w_blocked;
  assign w_emit    = w_accept & (w_acc_sum >= COL_L);
  assign w_drop    = w_tick & ((r_state == ST_HOLD) | ((r_state == ST_RUN) & w_blocked));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (run_i) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_blocked)                    w_state_nxt = ST_HOLD;
        else if (!run_i && !r_col_valid)  w_state_nxt = ST_IDLE;
      end
      ST_HOLD: if (w_hs) w_state_nxt = run_i ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_tog       <= 1'b0;
      r_offset    <= '0;
      r_acc       <= '0;
      r_col_valid <= 1'b0;
      r_data_en   <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tog   <= scroll_tog_i;
      r_stall <= w_drop;
      if (w_accept) begin
        r_offset <= w_off_nxt[9:0];
        r_acc    <= w_emit ? (w_acc_sum - COL_L) : w_acc_sum;
      end
      // A new column wins over a handshake completing in the same cycle.
      if (w_emit) begin
        r_col_valid <= 1'b1;
        r_data_en   <= 1'b1;
      end else if (w_hs) begin
        r_col_valid <= 1'b0;
      end
    end
  end

`ifdef SCROLL_ACCEL_EN
  logic [5:0] r_col_cnt;
  logic [1:0] r_level;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col_cnt <= '0;
      r_level   <= '0;
    end else if (w_hs) begin
      r_col_cnt <= r_col_cnt + 6'd1;
      if (r_col_cnt == 6'd63 && r_level != 2'd3) r_level <= r_level + 2'd1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = 2'd0;
`endif

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .adv_i   (w_emit),
    .state_o (w_lfsr)
  );

  // The LFSR only moves on emission, so its low byte is the held column height.
  assign col_data_o  = r_data_en ? w_lfsr[7:0] : 8'h00;
  assign offset_o    = r_offset;
  assign col_valid_o = r_col_valid;
  assign stall_o     = r_stall;
  assign level_o     = w_level;
  assign w_unused    = ^{w_lfsr[15:8], w_off_nxt[10]};

endmodule

// File: tb/tb_terrain_scroll.sv
// Self-checking bench for terrain_scroll: offset model plus column scoreboard.
module tb_terrain_scroll;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       tog = 1'b0;
  logic       run = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] speed = 2'd0;
  logic [9:0] offset_o;
  logic       col_valid_o;
  logic [7:0] col_data_o;
  logic       stall_o;
  logic [1:0] level_o;

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int hs_cnt = 0;
  int m_off, m_acc, m_cols;
  logic [15:0] m_lfsr;
  logic [7:0]  exp_q[$];

  terrain_scroll dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .scroll_tog_i (tog),
    .run_i        (run),
    .speed_i      (speed),
    .col_ready_i  (ready),
    .offset_o     (offset_o),
    .col_valid_o  (col_valid_o),
    .col_data_o   (col_data_o),
    .stall_o      (stall_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_nxt(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  function automatic int m_level();
`ifdef SCROLL_ACCEL_EN
    return (m_cols / 64 > 3) ? 3 : m_cols / 64;
`else
    return 0;
`endif
  endfunction

  // Column scoreboard: pops on every observed handshake.
  always @(negedge clk) begin : mon
    logic [7:0] e;
    if (rst_ni) begin
      if (stall_o) stall_cnt++;
      if (col_valid_o && ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL col_unexpected: got column %h, required none", col_data_o);
        end else begin
          e = exp_q.pop_front();
          if (col_data_o !== e) begin
            errors++;
            $display("FAIL col_data: got %h, required %h", col_data_o, e);
          end
        end
      end
    end
  end

  task automatic model_reset();
    m_off = 0; m_acc = 0; m_cols = 0; m_lfsr = 16'hACE1;
    exp_q.delete();
  endtask

  task automatic tick(input bit accept);
    int step;
    @(posedge clk); #1 tog = ~tog;
    if (accept) begin
      step  = speed + 1 + m_level();
      m_off = (m_off + step) % 640;
      m_acc = m_acc + step;
      if (m_acc >= 8) begin
        m_acc  = m_acc - 8;
        m_lfsr = lfsr_nxt(m_lfsr);
        exp_q.push_back(m_lfsr[7:0]);
        m_cols++;
      end
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (offset_o !== 10'(m_off)) begin
      errors++;
      $display("FAIL offset: got %0d, required %0d", offset_o, m_off);
    end
  endtask

  task automatic tick_until_column();
    int n = 0;
    while (exp_q.size() == 0 && n < 20) begin
      tick(1'b1);
      n++;
    end
    checks++;
    if (col_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL col_emit: got valid %b, required 1", col_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (offset_o !== 10'd0)   begin errors++; $display("FAIL rst_offset: got %0d, required 0", offset_o); end
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", col_valid_o); end
    if (col_data_o !== 8'h00) begin errors++; $display("FAIL rst_data: got %h, required 00", col_data_o); end
    if (stall_o !== 1'b0)     begin errors++; $display("FAIL rst_stall: got %b, required 0", stall_o); end
    if (level_o !== 2'd0)     begin errors++; $display("FAIL rst_level: got %0d, required 0", level_o); end
    model_reset();
    @(posedge clk); #1 rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int hs0;
    run = 1'b1; speed = 2'd0; ready = 1'b1;
    repeat (2) @(posedge clk);
    hs0 = hs_cnt;
    for (int i = 1; i <= 8; i++) begin
      tick(1'b1);
      checks++;
      if (offset_o !== 10'(i)) begin
        errors++;
        $display("FAIL basic_offset: got %0d, required %0d", offset_o, i);
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (hs_cnt - hs0 !== 1) begin errors++; $display("FAIL basic_cols: got %0d, required 1", hs_cnt - hs0); end
    if (col_data_o !== 8'h70) begin errors++; $display("FAIL basic_data: got %h, required 70", col_data_o); end
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid: got %b, required 0", col_valid_o); end
  endtask

  task automatic test_wrap();
    int n = 0;
    @(posedge clk); #1 speed = 2'd3;
    while (m_off != 636 && n < 400) begin
      tick(1'b1);
      n++;
    end
    if (m_level() == 0 && m_off == 636) begin
      tick(1'b1);
      checks++;
      if (offset_o !== 10'd0) begin errors++; $display("FAIL wrap_0: got %0d, required 0", offset_o); end
      tick(1'b1);
      checks++;
      if (offset_o !== 10'd4) begin errors++; $display("FAIL wrap_4: got %0d, required 4", offset_o); end
    end
  endtask

  task automatic test_hold();
    int s0;
    @(posedge clk); #1 speed = 2'd0; ready = 1'b0;
    tick_until_column();
    s0 = stall_cnt;
    repeat (3) tick(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (stall_cnt - s0 !== 3) begin errors++; $display("FAIL hold_stalls: got %0d, required 3", stall_cnt - s0); end
    if (col_valid_o !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b, required 1", col_valid_o); end
    if (exp_q.size() == 0 || col_data_o !== exp_q[0]) begin
      errors++; $display("FAIL hold_data: got %h, pending %0d", col_data_o, exp_q.size());
    end
    @(posedge clk); #1 ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (exp_q.size() !== 0)   begin errors++; $display("FAIL hold_drain: got %0d pending, required 0", exp_q.size()); end
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL hold_release: got %b, required 0", col_valid_o); end
    s0 = stall_cnt;
    tick(1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cnt !== s0) begin errors++; $display("FAIL resume_stall: got %0d, required %0d", stall_cnt, s0); end
  endtask

  task automatic test_stop_in_hold();
    int s0, s1, hs1;
    @(posedge clk); #1 ready = 1'b0;
    tick_until_column();
    @(posedge clk); #1 run = 1'b0;
    s0 = stall_cnt;
    repeat (2) tick(1'b0);
    @(posedge clk); #1 ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    s1 = stall_cnt;
    checks += 3;
    if (s1 - s0 !== 2)        begin errors++; $display("FAIL stop_stalls: got %0d, required 2", s1 - s0); end
    if (exp_q.size() !== 0)   begin errors++; $display("FAIL stop_drain: got %0d pending, required 0", exp_q.size()); end
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL stop_valid: got %b, required 0", col_valid_o); end
    hs1 = hs_cnt;
    repeat (3) tick(1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 2;
    if (stall_cnt !== s1) begin errors++; $display("FAIL idle_stall: got %0d, required %0d", stall_cnt, s1); end
    if (hs_cnt !== hs1)   begin errors++; $display("FAIL idle_cols: got %0d, required %0d", hs_cnt, hs1); end
    @(posedge clk); #1 run = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midhs();
    @(posedge clk); #1 ready = 1'b0; speed = 2'd0;
    tick_until_column();
    @(posedge clk); #3 rst_ni = 1'b0;
    #1;
    checks += 5;
    if (offset_o !== 10'd0)   begin errors++; $display("FAIL arst_offset: got %0d, required 0", offset_o); end
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b, required 0", col_valid_o); end
    if (col_data_o !== 8'h00) begin errors++; $display("FAIL arst_data: got %h, required 00", col_data_o); end
    if (stall_o !== 1'b0)     begin errors++; $display("FAIL arst_stall: got %b, required 0", stall_o); end
    if (level_o !== 2'd0)     begin errors++; $display("FAIL arst_level: got %0d, required 0", level_o); end
    model_reset();
    tog = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1; ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_valid_o !== 1'b0) begin errors++; $display("FAIL arst_nocol: got %b, required 0", col_valid_o); end
    repeat (8) tick(1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (col_data_o !== 8'h70) begin errors++; $display("FAIL arst_reseed: got %h, required 70", col_data_o); end
  endtask

  task automatic test_accel();
`ifdef SCROLL_ACCEL_EN
    int n = 0;
    int o0;
    @(posedge clk); #1 speed = 2'd0; ready = 1'b1;
    while (m_cols < 64 && n < 3000) begin tick(1'b1); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level_o !== 2'd1) begin errors++; $display("FAIL accel_l1: got %0d, required 1", level_o); end
    o0 = offset_o;
    tick(1'b1);
    checks++;
    if ((int'(offset_o) - o0 + 640) % 640 !== 2) begin
      errors++; $display("FAIL accel_step: got %0d, required 2", (int'(offset_o) - o0 + 640) % 640);
    end
    while (m_cols < 192 && n < 3000) begin tick(1'b1); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level_o !== 2'd3) begin errors++; $display("FAIL accel_l3: got %0d, required 3", level_o); end
    while (m_cols < 200 && n < 3000) begin tick(1'b1); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (level_o !== 2'd3) begin errors++; $display("FAIL accel_sat: got %0d, required 3", level_o); end
`else
    checks++;
    if (level_o !== 2'd0) begin errors++; $display("FAIL level_fixed: got %0d, required 0", level_o); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_stop_in_hold();
    test_reset_midhs();
    test_accel();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL final_drain: got %0d pending, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
